// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU slice:
// ALUOp encodings, 4-bit ALU control codes and legal R-type funct values.
package alu_pkg;

   localparam int DATA_WIDTH = 64;

   localparam logic [1:0] ALUOP_LS  = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_RSV = 2'b11;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // funct = {funct7, funct3}
   localparam logic [9:0] F_ADD = 10'b0000000_000;
   localparam logic [9:0] F_SUB = 10'b0100000_000;
   localparam logic [9:0] F_AND = 10'b0000000_111;
   localparam logic [9:0] F_OR  = 10'b0000000_110;
   localparam logic [9:0] F_SLT = 10'b0000000_010;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALU-control decode: (ALUOp, funct) -> 4-bit ALU op plus illegal flag.
// Unsupported combinations fall back to ADD so the datapath stays defined.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [9:0] funct,
   output logic [3:0] alu_ctrl,
   output logic       illegal
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      illegal  = 1'b0;
      unique case (alu_op)
         ALUOP_LS: alu_ctrl = ALU_ADD;
         ALUOP_BR: alu_ctrl = ALU_SUB;
         ALUOP_R: begin
            unique case (funct)
               F_ADD:   alu_ctrl = ALU_ADD;
               F_SUB:   alu_ctrl = ALU_SUB;
               F_AND:   alu_ctrl = ALU_AND;
               F_OR:    alu_ctrl = ALU_OR;
               F_SLT:   alu_ctrl = ALU_SLT;
               default: illegal  = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage slice: ALU control decode, 64-bit ALU, PC adders and
// next-PC select, all behind a single output register stage.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [1:0]            alu_op,
   input  logic [9:0]            funct,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic                  branch,
   output logic                  valid_out,
   output logic [3:0]            alu_ctrl,
   output logic [DATA_WIDTH-1:0] alu_result,
   output logic                  zero,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   output logic [DATA_WIDTH-1:0] branch_target,
   output logic [DATA_WIDTH-1:0] next_pc,
   output logic                  illegal
);

   localparam int DW = DATA_WIDTH;

   logic [3:0]    ctrl_c;
   logic          ill_c;
   logic [DW-1:0] res_c;
   logic          zero_c;
   logic          lt_c;
   logic [DW-1:0] p4_c;
   logic [DW-1:0] bt_c;
   logic [DW-1:0] np_c;

   alu_ctrl_decode u_dec (
      .alu_op   (alu_op),
      .funct    (funct),
      .alu_ctrl (ctrl_c),
      .illegal  (ill_c)
   );

   assign lt_c = $signed(operand_a) < $signed(operand_b);

   always_comb begin
      res_c = '0;
      unique case (ctrl_c)
         ALU_AND: res_c = operand_a & operand_b;
         ALU_OR:  res_c = operand_a | operand_b;
         ALU_ADD: res_c = operand_a + operand_b;
         ALU_SUB: res_c = operand_a - operand_b;
         ALU_SLT: res_c = {{(DW-1){1'b0}}, lt_c};
         ALU_NOR: res_c = ~(operand_a | operand_b);
         default: res_c = '0;
      endcase
   end

   // All adders wrap modulo 2^DW; imm<<1 drops its MSB.
   assign zero_c = (res_c == '0);
   assign p4_c   = pc + DW'(4);
   assign bt_c   = pc + {imm[DW-2:0], 1'b0};
   assign np_c   = (branch && zero_c) ? bt_c : p4_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out     <= 1'b0;
         alu_ctrl      <= '0;
         alu_result    <= '0;
         zero          <= 1'b0;
         pc_plus4      <= '0;
         branch_target <= '0;
         next_pc       <= '0;
         illegal       <= 1'b0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) begin
            alu_ctrl      <= ctrl_c;
            alu_result    <= res_c;
            zero          <= zero_c;
            pc_plus4      <= p4_c;
            branch_target <= bt_c;
            next_pc       <= np_c;
            illegal       <= ill_c;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes per-cycle expectations,
// a monitor pops and compares them one clock later.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [1:0]  alu_op;
   logic [9:0]  funct;
   logic [63:0] operand_a, operand_b, pc, imm;
   logic        branch;
   logic        valid_out;
   logic [3:0]  alu_ctrl;
   logic [63:0] alu_result;
   logic        zero;
   logic [63:0] pc_plus4, branch_target, next_pc;
   logic        illegal;

   always #5 clk = ~clk;

   alu_exec_unit dut (
      .clk           (clk),
      .reset         (reset),
      .valid_in      (valid_in),
      .alu_op        (alu_op),
      .funct         (funct),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .pc            (pc),
      .imm           (imm),
      .branch        (branch),
      .valid_out     (valid_out),
      .alu_ctrl      (alu_ctrl),
      .alu_result    (alu_result),
      .zero          (zero),
      .pc_plus4      (pc_plus4),
      .branch_target (branch_target),
      .next_pc       (next_pc),
      .illegal       (illegal)
   );

   typedef struct packed {
      logic        v;
      logic [3:0]  c;
      logic [63:0] r;
      logic        z;
      logic [63:0] p4;
      logic [63:0] bt;
      logic [63:0] np;
      logic        ill;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   exp_t  held;
   int    tests = 0;
   int    fails = 0;

   // Reference: what the instruction means, expressed directly in arithmetic.
   function automatic exp_t model(input logic [1:0] op, input logic [9:0] f,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] p, input logic [63:0] i,
                                  input logic br);
      exp_t e;
      e.v   = 1'b1;
      e.ill = 1'b0;
      e.c   = 4'd2;
      e.r   = a + b;
      if (op == 2'd1) begin
         e.c = 4'd6; e.r = a - b;
      end else if (op == 2'd2) begin
         if (f == 10'h000) begin
            e.c = 4'd2; e.r = a + b;
         end else if (f == 10'h100) begin
            e.c = 4'd6; e.r = a - b;
         end else if (f == 10'h007) begin
            e.c = 4'd0; e.r = a & b;
         end else if (f == 10'h006) begin
            e.c = 4'd1; e.r = a | b;
         end else if (f == 10'h002) begin
            e.c = 4'd7; e.r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         end else begin
            e.ill = 1'b1;
         end
      end else if (op == 2'd3) begin
         e.ill = 1'b1;
      end
      e.z  = (e.r == 64'd0);
      e.p4 = p + 64'd4;
      e.bt = p + i * 64'd2;
      e.np = (br && e.z) ? e.bt : e.p4;
      return e;
   endfunction

   task automatic drive(input logic rst, input logic v, input logic [1:0] op,
                        input logic [9:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] p,
                        input logic [63:0] i, input logic br,
                        input string tag);
      @(negedge clk);
      reset = rst; valid_in = v; alu_op = op; funct = f;
      operand_a = a; operand_b = b; pc = p; imm = i; branch = br;
      if (rst) held = '0;
      else if (v) held = model(op, f, a, b, p, i, br);
      else held.v = 1'b0;
      exp_q.push_back(held);
      tag_q.push_back(tag);
   endtask

   task automatic idle(input string tag);
      drive(1'b0, 1'b0, 2'($urandom), 10'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), tag);
   endtask

   initial begin : monitor
      exp_t  e;
      exp_t  got;
      string tag;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            got = '{valid_out, alu_ctrl, alu_result, zero, pc_plus4,
                    branch_target, next_pc, illegal};
            tests++;
            if (got !== e) begin
               fails++;
               $display("FAIL %s: got v=%b ctrl=%h res=%h z=%b p4=%h bt=%h np=%h ill=%b; expected v=%b ctrl=%h res=%h z=%b p4=%h bt=%h np=%h ill=%b",
                        tag, got.v, got.c, got.r, got.z, got.p4, got.bt, got.np, got.ill,
                        e.v, e.c, e.r, e.z, e.p4, e.bt, e.np, e.ill);
            end
         end
      end
   end

   logic [9:0] legal_f [5] = '{10'h000, 10'h100, 10'h007, 10'h006, 10'h002};

   initial begin : stim
      logic [63:0] a, b;
      logic [9:0]  f;
      int          k;
      held = '0;
      drive(1'b1, 1'b1, 2'd2, 10'h000, 64'd9, 64'd9, 64'h40, 64'd1, 1'b1, "reset0");
      drive(1'b1, 1'b1, 2'd2, 10'h000, 64'd9, 64'd9, 64'h40, 64'd1, 1'b1, "reset1");
      drive(1'b0, 1'b1, 2'd2, 10'h000, 64'd5, 64'd7, 64'h100, 64'd8, 1'b0, "rtype_add");
      drive(1'b0, 1'b1, 2'd1, 10'h000, 64'h1234, 64'h1234, 64'h200, 64'h10, 1'b1, "branch_taken");
      drive(1'b0, 1'b1, 2'd1, 10'h000, 64'h1234, 64'h1235, 64'h200, 64'h10, 1'b1, "branch_not_taken");
      drive(1'b0, 1'b1, 2'd2, 10'h007, 64'hF0, 64'h3C, 64'h0, 64'h0, 1'b0, "and");
      drive(1'b0, 1'b1, 2'd2, 10'h006, 64'hF0, 64'h3C, 64'h0, 64'h0, 1'b0, "or");
      drive(1'b0, 1'b1, 2'd2, 10'h002, '1, 64'd1, 64'h0, 64'h0, 1'b0, "slt_neg");
      drive(1'b0, 1'b1, 2'd2, 10'h002, 64'd1, '1, 64'h0, 64'h0, 1'b0, "slt_pos");
      drive(1'b0, 1'b1, 2'd2, 10'h100, 64'd3, 64'd5, 64'h8, 64'h0, 1'b0, "sub_wrap");
      drive(1'b0, 1'b1, 2'd0, 10'h3FF, '1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFC,
            64'h8000_0000_0000_0001, 1'b1, "add_wrap_pc_wrap");
      drive(1'b0, 1'b1, 2'd2, 10'h3FD, 64'd2, 64'd3, 64'h10, 64'h2, 1'b0, "illegal_rtype");
      drive(1'b0, 1'b1, 2'd3, 10'h000, 64'd2, 64'd3, 64'h10, 64'h2, 1'b0, "illegal_op11");
      idle("hold0");
      idle("hold1");
      idle("hold2");
      drive(1'b0, 1'b1, 2'd2, 10'h000, 64'd1, 64'd1, 64'h300, 64'h4, 1'b0, "pre_reset_op");
      drive(1'b1, 1'b1, 2'd2, 10'h000, 64'd4, 64'd4, 64'h400, 64'h4, 1'b1, "mid_reset");
      drive(1'b0, 1'b1, 2'd1, 10'h000, 64'd7, 64'd7, 64'h500, 64'h8, 1'b1, "post_reset_op");
      for (int n = 0; n < 400; n++) begin
         k = $urandom_range(0, 5);
         f = (k == 5) ? 10'($urandom) : legal_f[k];
         a = {$urandom, $urandom};
         b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 4));
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
               2'($urandom), f, a, b, {$urandom, $urandom},
               {$urandom, $urandom}, 1'($urandom), "random");
      end
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit reached, required finish");
      $fatal(1, "timeout");
   end

endmodule
